// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock-enable divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int CNT_W_DFLT       = 16;
    localparam int DEFAULT_DIV_DFLT = 32;
    localparam int TCNT_W_DFLT      = 8;

endpackage

// File: rtl/clk_div_if.sv
// Config/control/status bundle between the top-level control and clk_div_ctrl.
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DFLT,
    parameter int TCNT_W = TCNT_W_DFLT
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic              start;
    logic              stop;
    logic              tick;
    logic              busy;
    logic              done;
    logic [TCNT_W-1:0] tick_cnt;

    modport master (
        output cfg_valid, cfg_div, cfg_mode, start, stop,
        input  cfg_ready, tick, busy, done, tick_cnt
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_mode, start, stop,
        output cfg_ready, tick, busy, done, tick_cnt
    );
endinterface

// File: rtl/clk_div_counter.sv
// Free-running divide counter; term flags the last count of each period.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div_q,
    output logic             term
);
    logic [CNT_W-1:0] cnt_q;

    // div_q is never zero, so div_q-1 cannot underflow
    assign term = (cnt_q == (div_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= term ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator: config port, IDLE/RUN sequencing, tick and tick counter.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DFLT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT,
    parameter int TCNT_W      = TCNT_W_DFLT
) (
    input  logic      clk,
    input  logic      rst,
    clk_div_if.slave  bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_q;
    logic              mode_q;
    logic              tick_q;
    logic              done_q;
    logic [TCNT_W-1:0] tick_cnt_q;

    logic term;
    logic load_cfg;
    logic go;
    logic issue;
    logic done_set;

    function automatic logic [CNT_W-1:0] sat_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // Counter is held at zero in IDLE so a run always starts from a clean period
    clk_div_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == IDLE),
        .en    (state_q == RUN),
        .div_q (div_q),
        .term  (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        go       = 1'b0;
        issue    = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                load_cfg = bus.cfg_valid;
                if (bus.start) begin
                    go      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // stop outranks a coincident terminal count
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (term) begin
                    issue = 1'b1;
                    if (mode_q == MODE_ONESHOT) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= CNT_W'(DEFAULT_DIV);
            mode_q     <= MODE_PERIODIC;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            tick_q <= issue;
            if (load_cfg) begin
                div_q  <= sat_div(bus.cfg_div);
                mode_q <= bus.cfg_mode;
            end
            if (load_cfg || go) begin
                done_q <= 1'b0;
            end else if (done_set) begin
                done_q <= 1'b1;
            end
            if (go) begin
                tick_cnt_q <= '0;
            end else if (issue) begin
                tick_cnt_q <= tick_cnt_q + TCNT_W'(1);
            end
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.tick_cnt  = tick_cnt_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected tick cycles/counts queued at start, checked on tick.
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   e0;
    exp_t sb[$];

    clk_div_if #(.CNT_W(16), .TCNT_W(8)) bus ();

    clk_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(32), .TCNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tick === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexp_tick", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_cnt", bus.tick_cnt, e.cnt);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic load_cfg(input logic [15:0] d, input logic m);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = d;
        bus.cfg_mode  = m;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    // Queue every tick expected before edge e0+limit; one-shot expects only the first.
    task automatic start_run(input int n, input bit oneshot, input int limit,
                             input bit with_cfg, input logic [15:0] d, output int e);
        exp_t x;
        @(negedge clk);
        e = cyc + 1;
        for (int j = 1; j * n < limit; j++) begin
            x.cyc = e + j * n;
            x.cnt = j % 256;
            sb.push_back(x);
            if (oneshot) break;
        end
        if (with_cfg) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_div   = d;
            bus.cfg_mode  = oneshot;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("run_busy", bus.busy, 1'b1);
        chk("run_cfg_ready", bus.cfg_ready, 1'b0);
        chk("run_done_clr", bus.done, 1'b0);
        chk("run_tick_cnt0", bus.tick_cnt, 32'd0);
    endtask

    task automatic stop_at(input int e, input int off);
        wait_until(e + off - 1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_busy", bus.busy, 1'b0);
        chk("stop_tick", bus.tick, 1'b0);
        chk("stop_done", bus.done, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_mode  = MODE_PERIODIC;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_tick", bus.tick, 1'b0);
        chk("rst_tick_cnt", bus.tick_cnt, 32'd0);

        // Default /32 periodic, three ticks
        start_run(32, 1'b0, 97, 1'b0, '0, e0);
        stop_at(e0, 97);

        // /5 periodic, then ratio 0 treated as 1 with stop on a terminal edge
        load_cfg(16'd5, MODE_PERIODIC);
        start_run(5, 1'b0, 16, 1'b0, '0, e0);
        stop_at(e0, 16);
        load_cfg(16'd0, MODE_PERIODIC);
        start_run(1, 1'b0, 5, 1'b0, '0, e0);
        stop_at(e0, 5);

        // One-shot /4, done held until the next start
        load_cfg(16'd4, MODE_ONESHOT);
        start_run(4, 1'b1, 5, 1'b0, '0, e0);
        wait_until(e0 + 4);
        chk("os_busy", bus.busy, 1'b0);
        chk("os_done", bus.done, 1'b1);
        chk("os_cfg_ready", bus.cfg_ready, 1'b1);
        repeat (10) @(negedge clk);
        chk("os_done_hold", bus.done, 1'b1);
        start_run(4, 1'b1, 5, 1'b0, '0, e0);
        wait_until(e0 + 4);
        chk("os2_done", bus.done, 1'b1);
        repeat (6) @(negedge clk);

        // /3 with a rejected config mid-run and stop on the terminal edge
        load_cfg(16'd3, MODE_PERIODIC);
        start_run(3, 1'b0, 9, 1'b0, '0, e0);
        wait_until(e0 + 4);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 16'd9;
        bus.cfg_mode  = MODE_ONESHOT;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        stop_at(e0, 9);
        start_run(3, 1'b0, 7, 1'b0, '0, e0);
        stop_at(e0, 7);

        // Config and start together, then reset at cycle 3 of the run
        start_run(7, 1'b0, 3, 1'b1, 16'd7, e0);
        wait_until(e0 + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_tick", bus.tick, 1'b0);
        chk("mid_rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk("mid_rst_tick_cnt", bus.tick_cnt, 32'd0);
        start_run(32, 1'b0, 33, 1'b0, '0, e0);
        stop_at(e0, 33);

        // /1 for 257 ticks: tick_cnt wraps 255 -> 0 -> 1
        load_cfg(16'd1, MODE_PERIODIC);
        start_run(1, 1'b0, 258, 1'b0, '0, e0);
        stop_at(e0, 258);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
